av2_bool_decoder: RTL and testbench
===================================

AV2_BOOL_DECODER -- requirements
Module: av2_bool_decoder

Interface
REQ-001 Parameter CTX_W, default 16: width of context index and probability ports.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  one-cycle pulse; begins a new tile bitstream.
REQ-005 byte_in  in  8  next bitstream byte, MSB first.
REQ-006 byte_valid  in  1 / byte_ready  out  1  byte handshake; transfer when both high on an edge.
REQ-007 sym_req  in  1 / sym_ready  out  1  symbol request handshake; accept when both high on an edge.
REQ-008 sym_ctx  in  CTX_W  context index of the requested bit, sampled at accept.
REQ-009 context_idx  out  CTX_W  read address to context model.
REQ-010 context_prob  in  CTX_W  probability of bit==1 (x/256), valid one cycle after context_idx.
REQ-011 update_en  out  1 / update_idx  out  CTX_W / update_bit  out  1  context adaptation write.
REQ-012 reset_contexts  out  1  one-cycle pulse clearing all contexts.
REQ-013 bit_out  out  1 / bit_valid  out  1  decoded bit; bit_valid is a one-cycle pulse.

Function
REQ-014 The FSM SHALL use states IDLE, INIT0, INIT1, READY, FETCH, DECODE, NORM, FILL.
REQ-015 start in IDLE or READY SHALL go to INIT0 and pulse reset_contexts next cycle; start elsewhere is ignored.
REQ-016 INIT0/INIT1 SHALL assert byte_ready and load value[15:8], then value[7:0]; range=255, cnt=8; then READY.
REQ-017 sym_ready SHALL be high only in READY; accept latches sym_ctx into context_idx and goes to FETCH.
REQ-018 FETCH lasts exactly one cycle; DECODE uses context_prob in that cycle.
REQ-019 p8 = context_prob clamped to [1,255] (0->1, >255->255).
REQ-020 split = 1 + (((range-1)*p8) >> 8), 16-bit intermediate; split always in [1, range-1].
REQ-021 value[15:8] < split: bit=1, range=split; else bit=0, range-=split, value[15:8]-=split.
REQ-022 In the cycle after DECODE, bit_valid, update_en SHALL be high for one cycle with bit_out=update_bit=bit, update_idx=context_idx; accept-to-bit_valid latency = 3 cycles with no normalization.
REQ-023 After DECODE: range<128 -> NORM, else READY.
REQ-024 NORM: if cnt==0 go to FILL; else range<<=1, value<<=1, cnt-=1, one bit per cycle, until range>=128, then READY.
REQ-025 FILL: byte_ready high; on transfer value[7:0]=byte_in, cnt=8, back to NORM; stalls indefinitely without byte_valid.
REQ-026 byte_ready SHALL be low outside INIT0, INIT1, FILL.
REQ-027 A same-context symbol accepted back-to-back SHALL see the updated probability (update write precedes next FETCH read).
REQ-028 A stream with value[15:8] >= range is out of contract; behaviour unspecified but FSM must not lock (returns via NORM/READY).

Reset
REQ-029 rst_n low at an edge SHALL force IDLE, range=0, value=0, cnt=0, and all outputs 0, regardless of state, including mid-FILL or mid-NORM; no pending update or bit is emitted.

Structure
REQ-030 Package av2_bool_pkg SHALL hold the state encoding, PROB_MIN=1, PROB_MAX=255, RANGE_INIT=255, NORM_THRESH=128.
REQ-031 Split computation SHALL be one combinational sub-module av2_bool_split (range, p8 -> split); all other logic in av2_bool_decoder.

Verification
REQ-032 start, bytes 0x00,0x00; sym ctx=5, prob=128 -> split=128, bit_out=1, update_idx=5, update_bit=1, range=128, no NORM, bit_valid 3 cycles after accept.
REQ-033 start, bytes 0xF0,0x00; prob=128 -> bit_out=0, range 127 -> one NORM cycle, range=254, value[15:8]=0xE0.
REQ-034 Repeated prob=255 decodes forcing range<128 nine shifts -> FILL asserts byte_ready; hold byte_valid low 5 cycles -> no bit_valid, sym_ready low; then byte transfers and decoding resumes.
REQ-035 prob=0 and prob=0x0300 -> decoder uses p8=1 and p8=255 respectively (split 1 and 254 at range 255).
REQ-036 rst_n low during NORM -> next cycle IDLE, all outputs 0; start while in DECODE -> ignored.
REQ-037 Two back-to-back accepts on ctx=7 with a real context model -> second DECODE sees prob 129 after a first bit of 1.

Source files
------------

// File: rtl/av2_bool_pkg.sv
// av2_bool_pkg
// Shared definitions for the AV2 boolean (binary arithmetic) decoder.
// Holds the decoder FSM state encoding and the range/probability constants
// used by av2_bool_decoder and av2_bool_split.
package av2_bool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT0,
    INIT1,
    READY,
    FETCH,
    DECODE,
    NORM,
    FILL
  } state_e;

  // Probabilities are x/256; 0 and 256+ are clamped into this window so the
  // split never collapses onto either end of the range.
  localparam logic [7:0] PROB_MIN    = 8'd1;
  localparam logic [7:0] PROB_MAX    = 8'd255;

  localparam logic [7:0] RANGE_INIT  = 8'd255;
  localparam logic [7:0] NORM_THRESH = 8'd128;

  // Bits of fresh stream data held below value[15:8] after a byte load.
  localparam logic [3:0] CNT_INIT    = 4'd8;

endpackage

// File: rtl/av2_bool_split.sv
// av2_bool_split
// Combinational split-point computation for one boolean decode step:
//   split = 1 + (((range - 1) * p8) >> 8)
// For range >= 2 and p8 in [1,255] the result lies in [1, range-1].
// Ports:
//   range_in  in  8  current arithmetic-coder range
//   p8        in  8  clamped probability of bit==1 (x/256)
//   split     out 8  boundary between the '1' and '0' sub-intervals
module av2_bool_split
  import av2_bool_pkg::*;
(
  input  logic [7:0] range_in,
  input  logic [7:0] p8,
  output logic [7:0] split
);

  logic [7:0] range_m1;
  logic [7:0] prod_hi;
  logic [7:0] prod_lo_unused;

  // 254 * 255 = 64770, so the product always fits the 16-bit intermediate.
  assign range_m1 = range_in - 8'd1;
  assign {prod_hi, prod_lo_unused} = {8'd0, range_m1} * {8'd0, p8};
  assign split = 8'd1 + prod_hi;

endmodule

// File: rtl/av2_bool_decoder.sv
// av2_bool_decoder
// Tile-level boolean decoder: pulls bitstream bytes, fetches the probability
// for each requested context from an external context model, decodes one bit
// per request and emits an adaptation write for that context.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start                         pulse: begin a new tile bitstream
//   byte_in/byte_valid/byte_ready bitstream byte handshake
//   sym_req/sym_ready/sym_ctx     symbol request handshake and its context
//   context_idx/context_prob      context model read (prob one cycle later)
//   update_en/update_idx/update_bit  context adaptation write
//   reset_contexts                pulse: clear all contexts
//   bit_out/bit_valid             decoded bit, one-cycle valid pulse
module av2_bool_decoder
  import av2_bool_pkg::*;
#(
  parameter int CTX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             sym_req,
  output logic             sym_ready,
  input  logic [CTX_W-1:0] sym_ctx,
  output logic [CTX_W-1:0] context_idx,
  input  logic [CTX_W-1:0] context_prob,
  output logic             update_en,
  output logic [CTX_W-1:0] update_idx,
  output logic             update_bit,
  output logic             reset_contexts,
  output logic             bit_out,
  output logic             bit_valid
);

  state_e           state_q, state_d;
  logic [7:0]       range_q, range_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CTX_W-1:0] context_idx_q, context_idx_d;
  logic [CTX_W-1:0] update_idx_q, update_idx_d;
  logic             update_en_q, update_en_d;
  logic             update_bit_q, update_bit_d;
  logic             reset_contexts_q, reset_contexts_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             byte_ready_q, byte_ready_d;
  logic             sym_ready_q, sym_ready_d;

  logic [7:0]       p8;
  logic [7:0]       split;
  logic             dec_bit;
  logic [7:0]       dec_range;
  logic [7:0]       dec_value_hi;
  logic [7:0]       range_shl;

  av2_bool_split u_split (
    .range_in (range_q),
    .p8       (p8),
    .split    (split)
  );

  // Clamp the context probability into [1,255] and resolve the decode
  // outcome; only consumed while in DECODE.
  always_comb begin
    if (context_prob == '0) begin
      p8 = PROB_MIN;
    end else if (context_prob > CTX_W'(PROB_MAX)) begin
      p8 = PROB_MAX;
    end else begin
      p8 = context_prob[7:0];
    end

    dec_bit = (value_q[15:8] < split);
    if (dec_bit) begin
      dec_range    = split;
      dec_value_hi = value_q[15:8];
    end else begin
      dec_range    = range_q - split;
      dec_value_hi = value_q[15:8] - split;
    end

    range_shl = {range_q[6:0], 1'b0};
  end

  // Next-state and next-output logic. Handshake readies are derived from the
  // next state so that they are registered yet always match the current state.
  always_comb begin
    state_d          = state_q;
    range_d          = range_q;
    value_d          = value_q;
    cnt_d            = cnt_q;
    context_idx_d    = context_idx_q;
    update_idx_d     = update_idx_q;
    update_bit_d     = update_bit_q;
    bit_out_d        = bit_out_q;
    update_en_d      = 1'b0;
    bit_valid_d      = 1'b0;
    reset_contexts_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d          = INIT0;
          reset_contexts_d = 1'b1;
        end
      end
      INIT0: begin
        if (byte_valid && byte_ready_q) begin
          value_d[15:8] = byte_in;
          state_d       = INIT1;
        end
      end
      INIT1: begin
        if (byte_valid && byte_ready_q) begin
          value_d[7:0] = byte_in;
          range_d      = RANGE_INIT;
          cnt_d        = CNT_INIT;
          state_d      = READY;
        end
      end
      READY: begin
        // A restart takes priority over any symbol request in the same cycle.
        if (start) begin
          state_d          = INIT0;
          reset_contexts_d = 1'b1;
        end else if (sym_req && sym_ready_q) begin
          context_idx_d = sym_ctx;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        range_d       = dec_range;
        value_d[15:8] = dec_value_hi;
        bit_out_d     = dec_bit;
        update_bit_d  = dec_bit;
        update_idx_d  = context_idx_q;
        bit_valid_d   = 1'b1;
        update_en_d   = 1'b1;
        state_d       = (dec_range < NORM_THRESH) ? NORM : READY;
      end
      NORM: begin
        // Out of buffered bits: refill before shifting further.
        if (cnt_q == 4'd0) begin
          state_d = FILL;
        end else begin
          range_d = range_shl;
          value_d = {value_q[14:0], 1'b0};
          cnt_d   = cnt_q - 4'd1;
          state_d = (range_shl >= NORM_THRESH) ? READY : NORM;
        end
      end
      FILL: begin
        if (byte_valid && byte_ready_q) begin
          value_d[7:0] = byte_in;
          cnt_d        = CNT_INIT;
          state_d      = NORM;
        end
      end
    endcase

    byte_ready_d = (state_d == INIT0) || (state_d == INIT1) || (state_d == FILL);
    sym_ready_d  = (state_d == READY);
  end

  // Single register stage for FSM state, datapath and all outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      range_q          <= '0;
      value_q          <= '0;
      cnt_q            <= '0;
      context_idx_q    <= '0;
      update_idx_q     <= '0;
      update_en_q      <= 1'b0;
      update_bit_q     <= 1'b0;
      reset_contexts_q <= 1'b0;
      bit_out_q        <= 1'b0;
      bit_valid_q      <= 1'b0;
      byte_ready_q     <= 1'b0;
      sym_ready_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      range_q          <= range_d;
      value_q          <= value_d;
      cnt_q            <= cnt_d;
      context_idx_q    <= context_idx_d;
      update_idx_q     <= update_idx_d;
      update_en_q      <= update_en_d;
      update_bit_q     <= update_bit_d;
      reset_contexts_q <= reset_contexts_d;
      bit_out_q        <= bit_out_d;
      bit_valid_q      <= bit_valid_d;
      byte_ready_q     <= byte_ready_d;
      sym_ready_q      <= sym_ready_d;
    end
  end

  assign byte_ready     = byte_ready_q;
  assign sym_ready      = sym_ready_q;
  assign context_idx    = context_idx_q;
  assign update_en      = update_en_q;
  assign update_idx     = update_idx_q;
  assign update_bit     = update_bit_q;
  assign reset_contexts = reset_contexts_q;
  assign bit_out        = bit_out_q;
  assign bit_valid      = bit_valid_q;

endmodule

// File: tb/tb_av2_bool_decoder.sv
// tb_av2_bool_decoder
// Directed bench for av2_bool_decoder with a small adaptive context model
// (+1 on a decoded 1, -1 on a decoded 0, reset to 128) and an override path
// for driving out-of-range probabilities.
module tb_av2_bool_decoder;

  localparam int CTX_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             sym_req;
  logic             sym_ready;
  logic [CTX_W-1:0] sym_ctx;
  logic [CTX_W-1:0] context_idx;
  logic [CTX_W-1:0] context_prob;
  logic             update_en;
  logic [CTX_W-1:0] update_idx;
  logic             update_bit;
  logic             reset_contexts;
  logic             bit_out;
  logic             bit_valid;

  av2_bool_decoder #(.CTX_W(CTX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .sym_req        (sym_req),
    .sym_ready      (sym_ready),
    .sym_ctx        (sym_ctx),
    .context_idx    (context_idx),
    .context_prob   (context_prob),
    .update_en      (update_en),
    .update_idx     (update_idx),
    .update_bit     (update_bit),
    .reset_contexts (reset_contexts),
    .bit_out        (bit_out),
    .bit_valid      (bit_valid)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Context model: synchronous read, adaptation write on update_en.
  logic [7:0]       ctx_mem [0:255];
  logic             prob_force_en;
  logic [CTX_W-1:0] prob_force_val;
  logic [CTX_W-1:0] prob_q;

  always @(posedge clk) begin
    if (reset_contexts) begin
      for (int i = 0; i < 256; i++) ctx_mem[i] <= 8'd128;
    end else if (update_en) begin
      if (update_bit && ctx_mem[update_idx[7:0]] != 8'd255)
        ctx_mem[update_idx[7:0]] <= ctx_mem[update_idx[7:0]] + 8'd1;
      else if (!update_bit && ctx_mem[update_idx[7:0]] != 8'd1)
        ctx_mem[update_idx[7:0]] <= ctx_mem[update_idx[7:0]] - 8'd1;
    end
    prob_q <= prob_force_en ? prob_force_val : {8'd0, ctx_mem[context_idx[7:0]]};
  end

  assign context_prob = prob_q;

  typedef struct {
    logic             b;
    logic [CTX_W-1:0] idx;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [CTX_W-1:0] p;
  int               acc;
  int               guard;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every decoded bit must match the oldest outstanding request, including
  // its due cycle (third cycle after the accept cycle).
  always @(negedge clk) begin
    if (bit_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_bit_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("bit_out", {31'd0, bit_out}, {31'd0, mon_e.b});
        checkOutput("update_en", {31'd0, update_en}, 32'd1);
        checkOutput("update_bit", {31'd0, update_bit}, {31'd0, mon_e.b});
        checkOutput("update_idx", {16'd0, update_idx}, {16'd0, mon_e.idx});
        checkOutput("bit_latency", cycle_cnt, mon_e.due);
      end
    end
  end

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    checkOutput({tag, "_sym_ready"}, {31'd0, sym_ready}, 32'd0);
    checkOutput({tag, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
    checkOutput({tag, "_bit_out"}, {31'd0, bit_out}, 32'd0);
    checkOutput({tag, "_update_en"}, {31'd0, update_en}, 32'd0);
    checkOutput({tag, "_update_bit"}, {31'd0, update_bit}, 32'd0);
    checkOutput({tag, "_update_idx"}, {16'd0, update_idx}, 32'd0);
    checkOutput({tag, "_context_idx"}, {16'd0, context_idx}, 32'd0);
    checkOutput({tag, "_reset_contexts"}, {31'd0, reset_contexts}, 32'd0);
  endtask

  // All driver tasks are entered and left just after a falling edge.
  task automatic sendByte(input logic [7:0] b);
    int g = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("reset_contexts_pulse", {31'd0, reset_contexts}, 32'd1);
    sendByte(b0);
    checkOutput("reset_contexts_clear", {31'd0, reset_contexts}, 32'd0);
    sendByte(b1);
  endtask

  // exp_shift < 0 skips the normalization-length check.
  task automatic decodeSym(input logic [CTX_W-1:0] ctx, input logic exp_bit,
                           input int exp_shift, output logic [CTX_W-1:0] seen_prob);
    int g = 0;
    int a;
    seen_prob = '0;
    sym_req   = 1'b1;
    sym_ctx   = ctx;
    while (!sym_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!sym_ready) begin
      checkOutput("sym_ready_timeout", 32'd0, 32'd1);
      sym_req = 1'b0;
      return;
    end
    a = cycle_cnt;
    exp_q.push_back('{exp_bit, ctx, a + 3});
    @(posedge clk);
    @(negedge clk);
    sym_req = 1'b0;
    checkOutput("sym_ready_after_accept", {31'd0, sym_ready}, 32'd0);
    @(negedge clk);
    seen_prob = context_prob;
    if (exp_shift >= 0) begin
      g = 0;
      while (!sym_ready && g < 64) begin
        @(negedge clk);
        g++;
      end
      checkOutput("norm_cycles", cycle_cnt - (a + 3), exp_shift);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    byte_in        = 8'h00;
    byte_valid     = 1'b0;
    sym_req        = 1'b0;
    sym_ctx        = '0;
    prob_force_en  = 1'b0;
    prob_force_val = '0;

    repeat (3) @(negedge clk);
    checkOutputsZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_sym_ready", {31'd0, sym_ready}, 32'd0);
    checkOutput("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

    // Value 0x0000, prob 128: split 128, bit 1, range 128, no shift.
    $display("[TB] basic decode");
    applyStimulus(8'h00, 8'h00);
    decodeSym(16'd5, 1'b1, 0, p);
    checkOutput("basic_prob", {16'd0, p}, 32'd128);

    // Restart from READY. Value 0xF000, prob 128: bit 0, range 127 -> one
    // shift to range 254, value_hi 0xE0. Then prob 127: split 126, bit 0.
    $display("[TB] zero bit with one normalization");
    applyStimulus(8'hF0, 8'h00);
    decodeSym(16'd3, 1'b0, 1, p);
    decodeSym(16'd3, 1'b0, 0, p);
    checkOutput("zero_prob_adapted", {16'd0, p}, 32'd127);

    // prob 0x0300 -> p8 255, split 254: bit 1, range 254.
    // prob 0 at range 254 -> p8 1, split 1: bit 1, range 1, seven shifts.
    $display("[TB] probability clamping");
    prob_force_en  = 1'b1;
    prob_force_val = 16'h0300;
    applyStimulus(8'h00, 8'h00);
    decodeSym(16'd1, 1'b1, 0, p);
    prob_force_val = 16'h0000;
    decodeSym(16'd1, 1'b1, 7, p);

    // Value 0xFF00, prob 255: split 254, bit 0, range 1, seven shifts.
    // Next: range 128, split 127, value_hi 128 -> bit 0, range 1; one shift
    // empties the bit count, so the decoder stalls in FILL.
    $display("[TB] refill stall");
    prob_force_val = 16'd255;
    applyStimulus(8'hFF, 8'h00);
    decodeSym(16'd2, 1'b0, 7, p);
    decodeSym(16'd2, 1'b0, -1, p);
    guard = 0;
    while (!byte_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("fill_byte_ready", {31'd0, byte_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("fill_stall_byte_ready", {31'd0, byte_ready}, 32'd1);
      checkOutput("fill_stall_sym_ready", {31'd0, sym_ready}, 32'd0);
      checkOutput("fill_stall_bit_valid", {31'd0, bit_valid}, 32'd0);
    end
    prob_force_val = 16'd128;
    sendByte(8'h00);
    acc   = cycle_cnt;
    guard = 0;
    while (!sym_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("fill_renorm_cycles", cycle_cnt - acc, 6);
    // range 128, value_hi 0x80, prob 128: split 64, bit 0, range 64, one shift.
    decodeSym(16'd2, 1'b0, 1, p);

    // Reset while normalizing: split 1 at range 255 forces a long NORM.
    $display("[TB] reset during normalization");
    prob_force_val = 16'd0;
    applyStimulus(8'h00, 8'h00);
    decodeSym(16'd4, 1'b1, -1, p);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutputsZero("norm_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_sym_ready", {31'd0, sym_ready}, 32'd0);
    checkOutput("post_reset_byte_ready", {31'd0, byte_ready}, 32'd0);

    // start during DECODE must not restart the decoder.
    $display("[TB] start ignored in decode");
    prob_force_en = 1'b0;
    applyStimulus(8'h00, 8'h00);
    decodeSym(16'd9, 1'b1, -1, p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("decode_start_reset_contexts", {31'd0, reset_contexts}, 32'd0);
    checkOutput("decode_start_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("decode_start_sym_ready", {31'd0, sym_ready}, 32'd1);

    // Back-to-back on ctx 7: second fetch must see the adapted 129.
    $display("[TB] back-to-back same context");
    applyStimulus(8'h00, 8'h00);
    decodeSym(16'd7, 1'b1, 0, p);
    checkOutput("b2b_prob_first", {16'd0, p}, 32'd128);
    decodeSym(16'd7, 1'b1, 1, p);
    checkOutput("b2b_prob_second", {16'd0, p}, 32'd129);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
